// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// MulticycleController (module multicycle_controller)
//
// Control FSM for the multi-cycle 6-bit-opcode CPU. It walks every
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and handshakes
// with instruction and data memories that may insert wait states. A local
// copy of the opcode is captured on the same edge the datapath IR loads, so
// decode and execute outputs can be derived from it.
//
// Ports
//   clk_i            clock, every state change on the rising edge
//   rst_ni           synchronous reset, active low; forces all outputs to 0
//   instr_i          opcode bits from imem read data
//   imem_ack_i       imem data valid / transfer done
//   dmem_ack_i       dmem transfer done
//   flag_z_i         registered ALU zero flag
//   flag_c_i         registered ALU carry flag
//   imem_req_o       instruction fetch request
//   dmem_req_o       data memory request
//   dmem_we_o        1 = store, meaningful while dmem_req_o is high
//   ir_en_o          load IR (imem_req_o & imem_ack_i)
//   pc_en_o          update PC this cycle
//   pc_sel_o         00 PC+1, 01 PC+offset, 10 constant target
//   alu_op_o         ALU function, always the low IR bits
//   alu_src_const_o  0 = register operand B, 1 = immediate
//   flags_en_o       latch ALU flags
//   rf_we_o          register file write enable
//   rf_wsel_o        0 = ALU result, 1 = memory data
//   halted_o         in HALT state
//   error_o          in ERROR state (sticky until reset)
// ---------------------------------------------------------------------------
module multicycle_controller #(
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [5:0]          instr_i,
   input  logic                imem_ack_i,
   input  logic                dmem_ack_i,
   input  logic                flag_z_i,
   input  logic                flag_c_i,
   output logic                imem_req_o,
   output logic                dmem_req_o,
   output logic                dmem_we_o,
   output logic                ir_en_o,
   output logic                pc_en_o,
   output logic [1:0]          pc_sel_o,
   output logic [ALU_OP_W-1:0] alu_op_o,
   output logic                alu_src_const_o,
   output logic                flags_en_o,
   output logic                rf_we_o,
   output logic                rf_wsel_o,
   output logic                halted_o,
   output logic                error_o
);

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StHalt,
      StError
   } state_e;

   state_e           state_q, state_d;
   logic [5:0]       ir_q, ir_d;
   logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

   logic isR, isI, isMem, isLdm, isStm, isJcond, isJmp, isHalt, isIllegal;
   logic jcondTaken;
   logic waitLimit;

   // Opcode classes decoded from the captured IR copy. Anything that matches
   // none of the legal classes (bad MEM function codes, 1101xx, 1110xx and
   // 1111xx other than all-ones) is treated as illegal.
   assign isR       = (ir_q[5:4] == 2'b00);
   assign isI       = (ir_q[5:4] == 2'b01);
   assign isMem     = (ir_q[5:3] == 3'b100);
   assign isLdm     = isMem && (ir_q[2:0] == 3'b000);
   assign isStm     = isMem && (ir_q[2:0] == 3'b001);
   assign isJcond   = (ir_q[5:3] == 3'b101);
   assign isJmp     = (ir_q[5:2] == 4'b1100);
   assign isHalt    = (ir_q == 6'b111111);
   assign isIllegal = !(isR || isI || isLdm || isStm || isJcond || isJmp || isHalt);

   // The wait that would bring the counter up to MEM_TIMEOUT without an ack
   // is the last one tolerated; an ack in that same cycle still completes.
   assign waitLimit = (waitCnt_q == CNT_W'(MEM_TIMEOUT - 1));

   // Branch condition for JZ/JNZ/JC/JNC, evaluated on the flags seen in EXEC.
   always_comb begin
      jcondTaken = 1'b0;
      case (ir_q[2:1])
         2'b00:   jcondTaken = flag_z_i;
         2'b01:   jcondTaken = !flag_z_i;
         2'b10:   jcondTaken = flag_c_i;
         default: jcondTaken = !flag_c_i;
      endcase
   end

   // State, IR copy and wait counter. The IR copy follows the datapath IR,
   // loading whenever a fetch is acknowledged.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StFetch;
         ir_q      <= '0;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   // Next-state logic. The wait counter only survives while a request is
   // pending without ack; every other cycle clears it, so it is always zero
   // on entry to FETCH or MEM.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = '0;
      ir_d      = ir_q;
      case (state_q)
         StFetch: begin
            if (imem_ack_i) begin
               ir_d    = instr_i;
               state_d = StDecode;
            end else if (waitLimit) begin
               state_d = StError;
            end else begin
               waitCnt_d = waitCnt_q + CNT_W'(1);
            end
         end
         StDecode: begin
            if (isIllegal) begin
               state_d = StError;
            end else if (isHalt) begin
               state_d = StHalt;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            if (isR || isI) begin
               state_d = StWb;
            end else if (isMem) begin
               state_d = StMem;
            end else begin
               state_d = StFetch;
            end
         end
         StMem: begin
            if (dmem_ack_i) begin
               state_d = isLdm ? StWb : StFetch;
            end else if (waitLimit) begin
               state_d = StError;
            end else begin
               waitCnt_d = waitCnt_q + CNT_W'(1);
            end
         end
         StWb:    state_d = StFetch;
         StHalt:  state_d = StHalt;
         StError: state_d = StError;
         default: state_d = StFetch;
      endcase
   end

   // Output decode from state and IR. Everything is held at zero while reset
   // is asserted so a request in flight drops in the reset cycle itself.
   // ir_en and the STM completion PC update are the only ack-dependent terms.
   always_comb begin
      imem_req_o      = 1'b0;
      dmem_req_o      = 1'b0;
      dmem_we_o       = 1'b0;
      ir_en_o         = 1'b0;
      pc_en_o         = 1'b0;
      pc_sel_o        = 2'b00;
      alu_op_o        = '0;
      alu_src_const_o = 1'b0;
      flags_en_o      = 1'b0;
      rf_we_o         = 1'b0;
      rf_wsel_o       = 1'b0;
      halted_o        = 1'b0;
      error_o         = 1'b0;
      if (rst_ni) begin
         alu_op_o = ir_q[ALU_OP_W-1:0];
         case (state_q)
            StFetch: begin
               imem_req_o = 1'b1;
               ir_en_o    = imem_ack_i;
            end
            StExec: begin
               alu_src_const_o = isI || isMem;
               flags_en_o      = isR || isI;
               if (isJmp) begin
                  pc_en_o  = 1'b1;
                  pc_sel_o = 2'b10;
               end else if (isJcond) begin
                  pc_en_o  = 1'b1;
                  pc_sel_o = jcondTaken ? 2'b01 : 2'b00;
               end
            end
            StMem: begin
               dmem_req_o = 1'b1;
               dmem_we_o  = isStm;
               pc_en_o    = isStm && dmem_ack_i;
            end
            StWb: begin
               rf_we_o   = 1'b1;
               rf_wsel_o = isLdm;
               pc_en_o   = 1'b1;
            end
            StHalt:  halted_o = 1'b1;
            StError: error_o  = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// Testbench for multicycle_controller.
//
// Each instruction is played out as a transaction: the bench picks an opcode,
// a number of imem and dmem wait states and the flag values, then derives the
// expected per-cycle output pattern from the instruction's class (R, I, LDM,
// STM, JCOND, JMP, HALT, illegal) and compares the DUT cycle by cycle.
// Directed cases come first, then a randomized stream.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

   localparam int MEM_TIMEOUT = 16;

   typedef struct packed {
      logic       imemReq;
      logic       dmemReq;
      logic       dmemWe;
      logic       irEn;
      logic       pcEn;
      logic [1:0] pcSel;
      logic [2:0] aluOp;
      logic       aluSrcConst;
      logic       flagsEn;
      logic       rfWe;
      logic       rfWsel;
      logic       halted;
      logic       error;
   } outV_t;

   // Instruction classes as the bench understands them.
   localparam int ClsR = 0, ClsI = 1, ClsLdm = 2, ClsStm = 3, ClsJcond = 4,
                  ClsJmp = 5, ClsHalt = 6, ClsIllegal = 7;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [5:0] instr = '0;
   logic       imemAck = 1'b0;
   logic       dmemAck = 1'b0;
   logic       flagZ = 1'b0;
   logic       flagC = 1'b0;
   logic       imemReq, dmemReq, dmemWe, irEn, pcEn;
   logic [1:0] pcSel;
   logic [2:0] aluOp;
   logic       aluSrcConst, flagsEn, rfWe, rfWsel, halted, error;

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   multicycle_controller #(
      .ALU_OP_W   (3),
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (5)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rstN),
      .instr_i        (instr),
      .imem_ack_i     (imemAck),
      .dmem_ack_i     (dmemAck),
      .flag_z_i       (flagZ),
      .flag_c_i       (flagC),
      .imem_req_o     (imemReq),
      .dmem_req_o     (dmemReq),
      .dmem_we_o      (dmemWe),
      .ir_en_o        (irEn),
      .pc_en_o        (pcEn),
      .pc_sel_o       (pcSel),
      .alu_op_o       (aluOp),
      .alu_src_const_o(aluSrcConst),
      .flags_en_o     (flagsEn),
      .rf_we_o        (rfWe),
      .rf_wsel_o      (rfWsel),
      .halted_o       (halted),
      .error_o        (error)
   );

   // Opcode class from its numeric value.
   function automatic int classify(input logic [5:0] op);
      int v;
      v = int'(op);
      if (v < 16) return ClsR;
      if (v < 32) return ClsI;
      if (v == 32) return ClsLdm;
      if (v == 33) return ClsStm;
      if (v < 40) return ClsIllegal;
      if (v < 48) return ClsJcond;
      if (v < 52) return ClsJmp;
      if (v == 63) return ClsHalt;
      return ClsIllegal;
   endfunction

   // Branch decision for a conditional jump given the flags.
   function automatic logic branchTaken(input logic [5:0] op, input logic z, input logic c);
      case (int'(op[2:1]))
         0:       return z;
         1:       return !z;
         2:       return c;
         default: return !c;
      endcase
   endfunction

   // Wait-state choice, biased toward short waits with some near/at the limit.
   function automatic int pickWait();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 14) return r % 4;
      if (r < 17) return MEM_TIMEOUT - 1;
      return MEM_TIMEOUT;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // mode 0: ALU fields don't-care; 1: alu_op cared; 2: alu_op and
   // alu_src_const cared; 3: every bit cared (reset).
   task automatic applyStimulus(input string tag, input outV_t e, input int mode);
      outV_t o;
      outV_t care;
      @(negedge clk);
      o.imemReq = imemReq;  o.dmemReq = dmemReq;  o.dmemWe = dmemWe;
      o.irEn = irEn;        o.pcEn = pcEn;        o.pcSel = pcSel;
      o.aluOp = aluOp;      o.aluSrcConst = aluSrcConst;
      o.flagsEn = flagsEn;  o.rfWe = rfWe;        o.rfWsel = rfWsel;
      o.halted = halted;    o.error = error;
      care = '1;
      if (mode == 0) begin
         care.aluOp = '0;
         care.aluSrcConst = 1'b0;
      end
      if (mode == 1) care.aluSrcConst = 1'b0;
      if (mode != 3) begin
         if (!e.pcEn) care.pcSel = '0;
         if (!e.dmemReq) care.dmemWe = 1'b0;
         if (!e.rfWe) care.rfWsel = 1'b0;
      end
      checkOutput(tag, o & care, e & care);
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      imemAck = 1'b0;
      dmemAck = 1'b0;
      applyStimulus("reset", '0, 3);
      rstN = 1'b1;
   endtask

   // Absorbing HALT/ERROR: random acks must not move it; then reset.
   task automatic holdTrap(input string tag, input outV_t e);
      for (int k = 0; k < 3; k++) begin
         imemAck = 1'($urandom);
         dmemAck = 1'($urandom);
         applyStimulus(tag, e, 0);
      end
      doReset();
   endtask

   task automatic runInstr(input logic [5:0] op, input int iw, input int dw,
                           input logic fz, input logic fc, input bit rstInMem);
      outV_t e;
      outV_t trapErr;
      int cls;
      cls = classify(op);
      trapErr = '0;
      trapErr.error = 1'b1;
      flagZ = fz;
      flagC = fc;

      for (int k = 0; k < iw && k < MEM_TIMEOUT; k++) begin
         imemAck = 1'b0;
         instr = 6'($urandom);
         e = '0; e.imemReq = 1'b1;
         applyStimulus("fetchWait", e, 0);
      end
      if (iw >= MEM_TIMEOUT) begin
         holdTrap("fetchTimeout", trapErr);
         return;
      end
      imemAck = 1'b1;
      instr = op;
      e = '0; e.imemReq = 1'b1; e.irEn = 1'b1;
      applyStimulus("fetchAck", e, 0);
      imemAck = 1'b0;
      instr = 6'($urandom);

      e = '0;
      applyStimulus("decode", e, 0);

      if (cls == ClsHalt) begin
         e = '0; e.halted = 1'b1;
         holdTrap("halt", e);
         return;
      end
      if (cls == ClsIllegal) begin
         holdTrap("illegal", trapErr);
         return;
      end

      e = '0;
      e.aluOp = op[2:0];
      case (cls)
         ClsR: begin
            e.flagsEn = 1'b1;
            applyStimulus("execR", e, 2);
         end
         ClsI: begin
            e.flagsEn = 1'b1;
            e.aluSrcConst = 1'b1;
            applyStimulus("execI", e, 2);
         end
         ClsLdm, ClsStm: begin
            e.aluSrcConst = 1'b1;
            applyStimulus("execMem", e, 2);
         end
         ClsJmp: begin
            e.pcEn = 1'b1;
            e.pcSel = 2'b10;
            applyStimulus("execJmp", e, 1);
            return;
         end
         default: begin
            e.pcEn = 1'b1;
            e.pcSel = branchTaken(op, fz, fc) ? 2'b01 : 2'b00;
            applyStimulus("execJcond", e, 1);
            return;
         end
      endcase

      if (cls == ClsLdm || cls == ClsStm) begin
         for (int k = 0; k < dw && k < MEM_TIMEOUT; k++) begin
            dmemAck = 1'b0;
            if (rstInMem && k == 0) begin
               doReset();
               return;
            end
            e = '0; e.dmemReq = 1'b1; e.dmemWe = (cls == ClsStm);
            applyStimulus("memWait", e, 0);
         end
         if (dw >= MEM_TIMEOUT) begin
            holdTrap("memTimeout", trapErr);
            return;
         end
         dmemAck = 1'b1;
         e = '0; e.dmemReq = 1'b1; e.dmemWe = (cls == ClsStm);
         e.pcEn = (cls == ClsStm);
         applyStimulus("memAck", e, 0);
         dmemAck = 1'b0;
         if (cls == ClsStm) return;
      end

      e = '0;
      e.rfWe = 1'b1;
      e.rfWsel = (cls == ClsLdm);
      e.pcEn = 1'b1;
      applyStimulus("writeBack", e, 0);
   endtask

   initial begin
      rstN = 1'b0;
      applyStimulus("resetHold", '0, 3);
      applyStimulus("resetHold", '0, 3);
      rstN = 1'b1;

      // Directed: R-type loop, LDM with waits, JZ both ways, fetch timeout,
      // halt, illegal MEM code, reset during STM memory wait, limit boundary.
      runInstr(6'b000011, 0, 0, 1'b0, 1'b0, 1'b0);
      runInstr(6'b000011, 0, 0, 1'b0, 1'b0, 1'b0);
      runInstr(6'b100000, 0, 3, 1'b0, 1'b0, 1'b0);
      runInstr(6'b101000, 0, 0, 1'b1, 1'b0, 1'b0);
      runInstr(6'b101000, 0, 0, 1'b0, 1'b0, 1'b0);
      runInstr(6'b000011, MEM_TIMEOUT, 0, 1'b0, 1'b0, 1'b0);
      runInstr(6'b111111, 0, 0, 1'b0, 1'b0, 1'b0);
      runInstr(6'b100111, 0, 0, 1'b0, 1'b0, 1'b0);
      runInstr(6'b100001, 0, 2, 1'b0, 1'b0, 1'b1);
      runInstr(6'b100001, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
      runInstr(6'b100000, 1, MEM_TIMEOUT, 1'b0, 1'b0, 1'b0);
      runInstr(6'b110001, 0, 0, 1'b0, 1'b1, 1'b0);

      for (int n = 0; n < 250; n++) begin
         runInstr(6'($urandom), pickWait(), pickWait(), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
